// File: rtl/serial_digit_adder.sv
// Digit-serial add/subtract: WIDTH/DIGIT RUN cycles from accept to out_valid.
// Accepts only in IDLE; the result holds in DONE until out_ready, no accept/result overlap.
module serial_digit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       op_a, op_b, res;
  logic                   carry;
  logic [CW-1:0]          cnt;
  logic                   a_msb, b_msb;
  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic                   accept, last;

  assign accept  = in_valid && (state_q == IDLE);
  assign last    = (cnt == CW'(N - 1));
  assign dsum    = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  // New digit enters at the top; after N shifts the result is fully aligned.
  assign res_cat = {dsum[DIGIT-1:0], res};

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (last) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      res     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a  <= a;
        op_b  <= b ^ {WIDTH{sub}};
        // In subtract mode cin is the not-borrow input: a + ~b + cin = a - b - ~cin.
        carry <= cin;
        cnt   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1] ^ sub;
      end else if (state_q == RUN) begin
        op_a  <= op_a >> DIGIT;
        op_b  <= op_b >> DIGIT;
        res   <= res_cat[WIDTH+DIGIT-1:DIGIT];
        carry <= dsum[DIGIT];
        cnt   <= cnt + CW'(1);
      end
    end
  end

  assign sum  = res;
  assign cout = carry;
  assign ovf  = (a_msb == b_msb) && (res[WIDTH-1] != a_msb);

endmodule
